move_ball: RTL and testbench



---
 rtl/breakout_pkg.sv | 37 +++
 rtl/move_ball_if.sv | 23 ++
 rtl/ball_axis.sv | 57 +++++
 rtl/move_ball.sv | 112 +++++++++++
 tb/tb_move_ball.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/breakout_pkg.sv
// Playfield geometry, ball/paddle dimensions and ball FSM encodings shared by
// the Breakout movers, so paddle and ball cannot disagree on sizes.
package breakout_pkg;

  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int H_BAR = 8;
  localparam int W_BAR = 64;
  localparam int R     = 4;
  localparam int STEP  = 2;

  localparam logic [9:0]  LIM_L   = 10'(R);
  localparam logic [9:0]  LIM_R   = 10'(SCR_W - R);
  localparam logic [9:0]  LIM_T   = 10'(R);
  localparam logic [9:0]  LIM_B   = 10'(SCR_H - R);
  localparam logic [9:0]  STEP_W  = 10'(STEP);
  localparam logic [9:0]  PAD_OFS = 10'(H_BAR + R);
  localparam logic [10:0] HIT_W   = 11'(W_BAR + R);

  localparam logic [9:0]  RST_X   = 10'd320;
  localparam logic [9:0]  RST_Y   = 10'd452;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    MOVE  = 2'd1,
    LOST  = 2'd2
  } state_t;

  // Unsigned distance between two 10-bit coordinates, one bit wider so it never wraps.
  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, b} - {1'b0, a};
    return d;
  endfunction

endpackage

// File: rtl/move_ball_if.sv
// Ball engine signal bundle: paddle position, tick and serve key in; ball
// position, event pulses and FSM state out.
interface move_ball_if;
  logic       tick;
  logic       launch;
  logic [9:0] bar_x;
  logic [9:0] bar_y;
  logic [9:0] x;
  logic [9:0] y;
  logic       bounce;
  logic       miss;
  logic [1:0] state;

  modport master (
    output tick, launch, bar_x, bar_y,
    input  x, y, bounce, miss, state
  );

  modport slave (
    input  tick, launch, bar_x, bar_y,
    output x, y, bounce, miss, state
  );
endinterface

// File: rtl/ball_axis.sv
// One ball axis: position and direction register that steps by STEP and
// reflects off a low and a high limit; a load port lets the owner place it.
module ball_axis
  import breakout_pkg::*;
#(
  parameter logic [9:0] RST_POS = 10'd0,
  parameter logic       RST_DIR = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       step,
  input  logic       load,
  input  logic [9:0] load_pos,
  input  logic       load_dir,
  input  logic       dir_ovr,
  input  logic       dir_ovr_val,
  input  logic [9:0] lim_lo,
  input  logic [9:0] lim_hi,
  output logic [9:0] pos,
  output logic       dir,
  output logic       refl
);

  logic [9:0] pos_d;
  logic       dir_d;

  // Limits are checked before stepping, so the subtraction never wraps.
  assign refl = dir ? (pos >= lim_hi - STEP_W) : (pos <= lim_lo + STEP_W);

  always_comb begin
    pos_d = pos;
    dir_d = dir;
    if (load) begin
      pos_d = load_pos;
      dir_d = load_dir;
    end else if (step) begin
      if (refl) begin
        pos_d = dir ? lim_hi : lim_lo;
        dir_d = ~dir;
      end else begin
        pos_d = dir ? pos + STEP_W : pos - STEP_W;
      end
      if (dir_ovr) dir_d = dir_ovr_val;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pos <= RST_POS;
      dir <= RST_DIR;
    end else begin
      pos <= pos_d;
      dir <= dir_d;
    end
  end

endmodule

// File: rtl/move_ball.sv
// Breakout ball motion engine: serves from the paddle, steps on each tick,
// reflects off walls and paddle, and flags a miss when the ball drops out.
module move_ball
  import breakout_pkg::*;
(
  input logic         clock,
  input logic         reset,
  move_ball_if.slave  bus
);

  state_t      state_q, state_d;
  logic        launch_q;
  logic        bounce_q, miss_q;
  logic [9:0]  x, y;
  logic        dir_x, dir_y;
  logic        refl_x, refl_y;
  logic [9:0]  pad_top;
  logic [10:0] y_next_ext;
  logic        hit, bottom;
  logic        serve_ld, move_tick, lost_now;
  logic        step_x, step_y, load_y;
  logic [9:0]  load_y_pos;

  assign pad_top    = bus.bar_y - PAD_OFS;
  assign y_next_ext = {1'b0, y} + {1'b0, STEP_W};
  assign hit        = dir_y && (y <= pad_top) && (y_next_ext >= {1'b0, pad_top})
                      && (abs_diff(x, bus.bar_x) <= HIT_W);
  assign bottom     = y_next_ext >= {1'b0, LIM_B};

  always_comb begin
    state_d   = state_q;
    serve_ld  = 1'b0;
    move_tick = 1'b0;
    lost_now  = 1'b0;
    case (state_q)
      SERVE: begin
        serve_ld = 1'b1;
        if (launch_q && !bus.launch) state_d = MOVE;
      end
      MOVE: begin
        if (bus.tick) begin
          move_tick = 1'b1;
          if (dir_y && !hit && bottom) begin
            lost_now = 1'b1;
            state_d  = LOST;
          end
        end
      end
      LOST:    state_d = SERVE;
      default: state_d = SERVE;
    endcase
  end

  // The losing tick freezes both axes; descending Y is placed by the paddle/bottom logic.
  assign step_x     = move_tick && !lost_now;
  assign step_y     = move_tick && !dir_y;
  assign load_y     = serve_ld || (move_tick && dir_y && !lost_now);
  assign load_y_pos = (serve_ld || hit) ? pad_top : y + STEP_W;

  ball_axis #(.RST_POS(RST_X), .RST_DIR(1'b1)) u_axis_x (
    .clock       (clock),
    .reset       (reset),
    .step        (step_x),
    .load        (serve_ld),
    .load_pos    (bus.bar_x),
    .load_dir    (1'b1),
    .dir_ovr     (move_tick && hit && (x != bus.bar_x)),
    .dir_ovr_val (x > bus.bar_x),
    .lim_lo      (LIM_L),
    .lim_hi      (LIM_R),
    .pos         (x),
    .dir         (dir_x),
    .refl        (refl_x)
  );

  ball_axis #(.RST_POS(RST_Y), .RST_DIR(1'b0)) u_axis_y (
    .clock       (clock),
    .reset       (reset),
    .step        (step_y),
    .load        (load_y),
    .load_pos    (load_y_pos),
    .load_dir    (!(serve_ld || hit)),
    .dir_ovr     (1'b0),
    .dir_ovr_val (1'b0),
    .lim_lo      (LIM_T),
    .lim_hi      (LIM_B),
    .pos         (y),
    .dir         (dir_y),
    .refl        (refl_y)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= SERVE;
      launch_q <= 1'b1;
      bounce_q <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      launch_q <= bus.launch;
      bounce_q <= step_x && (refl_x || (step_y && refl_y) || hit);
      miss_q   <= lost_now;
    end
  end

  assign bus.x      = x;
  assign bus.y      = y;
  assign bus.bounce = bounce_q;
  assign bus.miss   = miss_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_move_ball.sv
// Directed bench for move_ball: serve, launch edge, wall/corner reflection,
// paddle hit window, ball loss and reset from motion.
module tb_move_ball;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  move_ball_if bus();

  move_ball dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      cyc();
    end
    bus.tick = 1'b0;
  endtask

  // Reset, park the paddle, then give one launch press edge (key left held low).
  task automatic serve_and_launch(input logic [9:0] bx, input logic [9:0] by);
    reset = 1'b1; bus.tick = 1'b0; bus.launch = 1'b1;
    bus.bar_x = bx; bus.bar_y = by;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    bus.launch = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.tick = 1'b0; bus.launch = 1'b1;
    bus.bar_x = 10'd200; bus.bar_y = 10'd464;
    cyc(); cyc();
    reset = 1'b0;
    n_checks++;
    if ({bus.x, bus.y, bus.state, bus.bounce, bus.miss} !== {10'd320, 10'd452, 2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: x=%0d y=%0d st=%0d b=%0d m=%0d expected 320 452 0 0 0",
               bus.x, bus.y, bus.state, bus.bounce, bus.miss);
    end
    cyc();
    n_checks++;
    if ({bus.x, bus.y, bus.state, bus.miss} !== {10'd200, 10'd452, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL serve_track: x=%0d y=%0d st=%0d m=%0d expected 200 452 0 0",
               bus.x, bus.y, bus.state, bus.miss);
    end
  endtask

  task automatic test_launch();
    bus.launch = 1'b0;
    cyc();
    n_checks++;
    if (bus.state !== 2'd1) begin
      n_fail++;
      $display("FAIL launch_edge: state=%0d expected 1", bus.state);
    end
    repeat (20) cyc();
    n_checks++;
    if ({bus.x, bus.y, bus.state} !== {10'd200, 10'd452, 2'd1}) begin
      n_fail++;
      $display("FAIL launch_hold: x=%0d y=%0d st=%0d expected 200 452 1", bus.x, bus.y, bus.state);
    end
    bus.launch = 1'b1; cyc(); cyc();
    bus.launch = 1'b0; cyc(); cyc();
    ticks(1);
    n_checks++;
    if ({bus.x, bus.y, bus.state, bus.bounce} !== {10'd202, 10'd450, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL first_tick: x=%0d y=%0d st=%0d b=%0d expected 202 450 1 0",
               bus.x, bus.y, bus.state, bus.bounce);
    end
  endtask

  task automatic test_reset_mid_move();
    ticks(10);
    reset = 1'b1;
    cyc();
    n_checks++;
    if ({bus.x, bus.y, bus.state, bus.bounce, bus.miss} !== {10'd320, 10'd452, 2'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_move: x=%0d y=%0d st=%0d b=%0d m=%0d expected 320 452 0 0 0",
               bus.x, bus.y, bus.state, bus.bounce, bus.miss);
    end
    reset = 1'b0;
  endtask

  task automatic test_right_wall();
    serve_and_launch(10'd637, 10'd112);
    ticks(1);
    n_checks++;
    if ({bus.x, bus.y, bus.bounce} !== {10'd636, 10'd98, 1'b1}) begin
      n_fail++;
      $display("FAIL right_wall: x=%0d y=%0d b=%0d expected 636 98 1", bus.x, bus.y, bus.bounce);
    end
    cyc();
    n_checks++;
    if (bus.bounce !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_width: bounce=%0d expected 0", bus.bounce);
    end
    ticks(1);
    n_checks++;
    if ({bus.x, bus.y} !== {10'd634, 10'd96}) begin
      n_fail++;
      $display("FAIL after_right_wall: x=%0d y=%0d expected 634 96", bus.x, bus.y);
    end
  endtask

  task automatic test_corner();
    serve_and_launch(10'd637, 10'd649);
    ticks(316);
    n_checks++;
    if ({bus.x, bus.y, bus.bounce} !== {10'd6, 10'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL pre_corner: x=%0d y=%0d b=%0d expected 6 5 0", bus.x, bus.y, bus.bounce);
    end
    ticks(1);
    n_checks++;
    if ({bus.x, bus.y, bus.bounce} !== {10'd4, 10'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL corner: x=%0d y=%0d b=%0d expected 4 4 1", bus.x, bus.y, bus.bounce);
    end
    ticks(1);
    n_checks++;
    if ({bus.x, bus.y, bus.bounce} !== {10'd6, 10'd6, 1'b0}) begin
      n_fail++;
      $display("FAIL after_corner: x=%0d y=%0d b=%0d expected 6 6 0", bus.x, bus.y, bus.bounce);
    end
  endtask

  // Ball served at (100,8), top bounce leaves it at (104,4) heading down-right.
  task automatic descend_to_204();
    serve_and_launch(10'd100, 10'd20);
    ticks(2);
    n_checks++;
    if ({bus.x, bus.y, bus.bounce} !== {10'd104, 10'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL top_wall: x=%0d y=%0d b=%0d expected 104 4 1", bus.x, bus.y, bus.bounce);
    end
    bus.bar_y = 10'd1000;
    ticks(100);
  endtask

  task automatic test_paddle_hit();
    descend_to_204();
    bus.bar_x = 10'd372; bus.bar_y = 10'd217;
    ticks(1);
    n_checks++;
    if ({bus.x, bus.y, bus.bounce} !== {10'd306, 10'd205, 1'b1}) begin
      n_fail++;
      $display("FAIL paddle_edge_hit: x=%0d y=%0d b=%0d expected 306 205 1", bus.x, bus.y, bus.bounce);
    end
    ticks(1);
    n_checks++;
    if ({bus.x, bus.y, bus.bounce} !== {10'd304, 10'd203, 1'b0}) begin
      n_fail++;
      $display("FAIL paddle_redirect: x=%0d y=%0d b=%0d expected 304 203 0", bus.x, bus.y, bus.bounce);
    end
  endtask

  task automatic test_paddle_miss();
    descend_to_204();
    bus.bar_x = 10'd373; bus.bar_y = 10'd217;
    ticks(1);
    n_checks++;
    if ({bus.x, bus.y, bus.bounce} !== {10'd306, 10'd206, 1'b0}) begin
      n_fail++;
      $display("FAIL paddle_just_wide: x=%0d y=%0d b=%0d expected 306 206 0", bus.x, bus.y, bus.bounce);
    end
    ticks(1);
    n_checks++;
    if ({bus.x, bus.y} !== {10'd308, 10'd208}) begin
      n_fail++;
      $display("FAIL keeps_falling: x=%0d y=%0d expected 308 208", bus.x, bus.y);
    end
  endtask

  task automatic test_lost();
    descend_to_204();
    ticks(135);
    n_checks++;
    if ({bus.x, bus.y, bus.state} !== {10'd574, 10'd474, 2'd1}) begin
      n_fail++;
      $display("FAIL near_bottom: x=%0d y=%0d st=%0d expected 574 474 1", bus.x, bus.y, bus.state);
    end
    bus.bar_x = 10'd200; bus.bar_y = 10'd464;
    ticks(1);
    n_checks++;
    if ({bus.x, bus.y, bus.state, bus.miss, bus.bounce} !== {10'd574, 10'd474, 2'd2, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL lost: x=%0d y=%0d st=%0d m=%0d b=%0d expected 574 474 2 1 0",
               bus.x, bus.y, bus.state, bus.miss, bus.bounce);
    end
    cyc();
    n_checks++;
    if ({bus.state, bus.miss} !== {2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL back_to_serve: st=%0d m=%0d expected 0 0", bus.state, bus.miss);
    end
    cyc();
    n_checks++;
    if ({bus.x, bus.y, bus.state} !== {10'd200, 10'd452, 2'd0}) begin
      n_fail++;
      $display("FAIL reserve: x=%0d y=%0d st=%0d expected 200 452 0", bus.x, bus.y, bus.state);
    end
    repeat (5) cyc();
    n_checks++;
    if (bus.state !== 2'd0) begin
      n_fail++;
      $display("FAIL held_key_relaunch: state=%0d expected 0", bus.state);
    end
  endtask

  initial begin
    bus.tick = 1'b0; bus.launch = 1'b1;
    bus.bar_x = 10'd200; bus.bar_y = 10'd464;
    test_reset();
    test_launch();
    test_reset_mid_move();
    test_right_wall();
    test_corner();
    test_paddle_hit();
    test_paddle_miss();
    test_lost();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
